opc6_bus_responder: RTL

System-side responder for the OPC6 CPU bus: decodes the CPU's vpa/vda/vio/rnw strobes, stalls the CPU through `clken` while an external memory completes a req/ack transfer, and serves a small I/O register block containing a down-counting timer and an interrupt controller that drives the CPU's active-low `int_b[1:0]`. It sits between the CPU core and the board memory/peripheral fabric.

---
 rtl/opc6_bus_responder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/opc6_bus_responder.sv
// OPC6 CPU bus responder: stalls the CPU through clken around external memory
// req/ack transfers and serves a small I/O block with a down-counting timer and interrupt controller.
module opc6_bus_responder #(
    parameter logic [15:0] IO_BASE = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vpa,
    input  logic        vda,
    input  logic        vio,
    input  logic        rnw,
    input  logic [15:0] address,
    input  logic [15:0] dout,
    output logic [15:0] din,
    output logic        clken,
    output logic [1:0]  int_b,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_ifetch,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    input  logic        ext_irq
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_nxt;
    logic        io_go, mem_go, io_hit, io_wr, timer_ovr;
    logic [2:0]  idx;
    logic        t_en, t_auto, ext_q;
    logic [15:0] t_reload, t_count, scratch, rd_val;
    logic [1:0]  istat, imask, istat_set, istat_clr;

    always_comb begin
        state_nxt = state;
        clken     = 1'b0;
        io_go     = 1'b0;
        mem_go    = 1'b0;
        case (state)
            IDLE: begin
                clken = !(vpa | vda | vio);
                // vio wins over a simultaneous vda/vpa
                if (vio) begin
                    io_go     = 1'b1;
                    state_nxt = DONE;
                end else if (vpa | vda) begin
                    mem_go    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_ack) state_nxt = DONE;
            end
            DONE: begin
                clken     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_req   = (state == REQ);
    assign idx       = address[2:0];
    assign io_hit    = io_go && (address[15:3] == IO_BASE[15:3]);
    assign io_wr     = io_hit && !rnw;
    assign timer_ovr = io_wr && ((idx == 3'd0) || (idx == 3'd2));

    always_comb begin
        rd_val = 16'h0000;
        if (io_hit) begin
            case (idx)
                3'd0:    rd_val = {14'd0, t_auto, t_en};
                3'd1:    rd_val = t_reload;
                3'd2:    rd_val = t_count;
                3'd3:    rd_val = {14'd0, istat};
                3'd4:    rd_val = {14'd0, imask};
                3'd5:    rd_val = scratch;
                default: rd_val = 16'h0000;
            endcase
        end
    end

    always_comb begin
        istat_set    = 2'b00;
        istat_set[0] = t_en && (t_count == 16'd0) && !timer_ovr;
        istat_set[1] = ext_irq && !ext_q;
        istat_clr    = (io_wr && (idx == 3'd3)) ? dout[1:0] : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            din        <= 16'h0000;
            mem_addr   <= 16'h0000;
            mem_wdata  <= 16'h0000;
            mem_we     <= 1'b0;
            mem_ifetch <= 1'b0;
        end else begin
            state <= state_nxt;
            if (mem_go) begin
                mem_addr   <= address;
                mem_wdata  <= dout;
                mem_we     <= !rnw;
                mem_ifetch <= vpa;
            end
            if (io_go && rnw)
                din <= rd_val;
            else if ((state == REQ) && mem_ack && !mem_we)
                din <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t_en     <= 1'b0;
            t_auto   <= 1'b0;
            t_reload <= 16'h0000;
            t_count  <= 16'h0000;
            scratch  <= 16'h0000;
            istat    <= 2'b00;
            imask    <= 2'b00;
            ext_q    <= 1'b0;
            int_b    <= 2'b11;
        end else begin
            ext_q <= ext_irq;
            // set beats write-1-clear on the same bit
            istat <= (istat & ~istat_clr) | istat_set;
            int_b <= ~(istat & imask);
            if (io_wr && (idx == 3'd0)) begin
                t_en   <= dout[0];
                t_auto <= dout[1];
            end else if (io_wr && (idx == 3'd2)) begin
                t_count <= dout;
            end else if (t_en) begin
                if (t_count == 16'd0) begin
                    if (t_auto) t_count <= t_reload;
                    else        t_en    <= 1'b0;
                end else begin
                    t_count <= t_count - 16'd1;
                end
            end
            if (io_wr && (idx == 3'd1)) t_reload <= dout;
            if (io_wr && (idx == 3'd4)) imask    <= dout[1:0];
            if (io_wr && (idx == 3'd5)) scratch  <= dout;
        end
    end

endmodule
